// File: rtl/mem_port_arbiter.sv
// Shares the NextMemory port between IF and LS: grants are combinational, read data returns 1 cycle after the grant.
// Backpressure: a requester without a grant holds its request; LS wins contention until IF has been denied STARVE_LIMIT times in a row.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH   = 16,
   parameter int DATA_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_gnt,
   output logic                  if_rvalid,
   output logic [DATA_WIDTH-1:0] if_rdata,
   input  logic                  ls_req,
   input  logic                  ls_we,
   input  logic [ADDR_WIDTH-1:0] ls_addr,
   input  logic [DATA_WIDTH-1:0] ls_wdata,
   output logic                  ls_gnt,
   output logic                  ls_rvalid,
   output logic [DATA_WIDTH-1:0] ls_rdata,
   output logic                  mem_wen,
   output logic                  mem_ren,
   output logic [ADDR_WIDTH-1:0] mem_waddr,
   output logic [ADDR_WIDTH-1:0] mem_raddr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_LS   = 2'd2
   } owner_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   owner_t                resp_owner, resp_owner_nxt;
   logic [3:0]            starve_cnt, starve_cnt_nxt;
   logic [ADDR_WIDTH-1:0] raddr_q, waddr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  ls_rd_gnt, ls_wr_gnt;

   always_comb begin
      if_gnt         = 1'b0;
      ls_gnt         = 1'b0;
      ls_rd_gnt      = 1'b0;
      ls_wr_gnt      = 1'b0;
      mem_ren        = 1'b0;
      mem_wen        = 1'b0;
      mem_raddr      = raddr_q;
      mem_waddr      = waddr_q;
      mem_wdata      = wdata_q;
      starve_cnt_nxt = starve_cnt;
      resp_owner_nxt = OWN_NONE;

      // Grants are suppressed while reset is held, even with requests pending.
      if (rst) begin
         if (if_req && (!ls_req || starve_cnt >= LIMIT)) begin
            if_gnt = 1'b1;
         end else if (ls_req) begin
            ls_gnt = 1'b1;
         end
      end
      ls_rd_gnt = ls_gnt && !ls_we;
      ls_wr_gnt = ls_gnt && ls_we;

      if (if_gnt) begin
         mem_ren        = 1'b1;
         mem_raddr      = if_addr;
         resp_owner_nxt = OWN_IF;
      end else if (ls_rd_gnt) begin
         mem_ren        = 1'b1;
         mem_raddr      = ls_addr;
         resp_owner_nxt = OWN_LS;
      end else if (ls_wr_gnt) begin
         mem_wen   = 1'b1;
         mem_waddr = ls_addr;
         mem_wdata = ls_wdata;
      end

      if (!if_req || if_gnt) begin
         starve_cnt_nxt = 4'd0;
      end else if (starve_cnt < LIMIT) begin
         starve_cnt_nxt = starve_cnt + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         resp_owner <= OWN_NONE;
         starve_cnt <= 4'd0;
         raddr_q    <= '0;
         waddr_q    <= '0;
         wdata_q    <= '0;
      end else begin
         resp_owner <= resp_owner_nxt;
         starve_cnt <= starve_cnt_nxt;
         raddr_q    <= mem_raddr;
         waddr_q    <= mem_waddr;
         wdata_q    <= mem_wdata;
      end
   end

   // Read data is steered to whichever port owned last cycle's read; the other port sees zero.
   assign if_rvalid = (resp_owner == OWN_IF);
   assign ls_rvalid = (resp_owner == OWN_LS);
   assign if_rdata  = if_rvalid ? mem_rdata : '0;
   assign ls_rdata  = ls_rvalid ? mem_rdata : '0;

endmodule
